// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
// Optional phase-restart input is enabled with the CLKDIV_SYNC_EN macro.
package clk_div_pkg;

    localparam int DEFAULT_DIV = 2;
    localparam int MIN_DIV     = 2;
    localparam int MAX_CW      = 16;

    // Ratios 0 and 1 cannot produce a clock, so they fold onto the minimum ratio.
    function automatic logic [MAX_CW-1:0] clamp_div(input logic [MAX_CW-1:0] d);
        return (d < 16'(MIN_DIV)) ? 16'(MIN_DIV) : d;
    endfunction

    // High time of one period; odd ratios get the extra cycle high.
    function automatic logic [MAX_CW-1:0] high_time(input logic [MAX_CW-1:0] a);
        return a - (a >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active ratio and registered clk_out/tick.
// With CLKDIV_SYNC_EN defined, a sync port restarts the period at phase 0.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW      = 8,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
`ifdef CLKDIV_SYNC_EN
    input  logic          sync,
`endif
    input  logic [CW-1:0] div_val,
    output logic          clk_out,
    output logic          tick
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] act;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] act_nxt;
    logic [CW-1:0] div_clamped;
    logic [CW-1:0] high_nxt;
    logic          out_q;
    logic          tck_q;

    // The requested ratio is only picked up at terminal count, so a period
    // in flight always completes at the ratio it started with.
    always_comb begin
        div_clamped = CW'(clamp_div(16'(div_val)));
        cnt_nxt     = cnt + CW'(1);
        act_nxt     = act;
        if (cnt == act - CW'(1)) begin
            cnt_nxt = '0;
            act_nxt = div_clamped;
        end
        high_nxt = CW'(high_time(16'(act_nxt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            act   <= CW'(DEF_DIV);
            out_q <= 1'b0;
            tck_q <= 1'b0;
        end
`ifdef CLKDIV_SYNC_EN
        else if (sync) begin
            cnt   <= '0;
            act   <= div_clamped;
            out_q <= 1'b1;
            tck_q <= 1'b1;
        end
`endif
        else if (en) begin
            cnt   <= cnt_nxt;
            act   <= act_nxt;
            out_q <= (cnt_nxt < high_nxt);
            tck_q <= (cnt_nxt == '0);
        end else begin
            tck_q <= 1'b0;
        end
    end

    assign clk_out = out_q;
    assign tick    = tck_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; one clk_div_chan per channel.
// Optional sync port (phase restart of all channels) under CLKDIV_SYNC_EN.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int CW      = 8,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH*CW-1:0] div_val,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick
);

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        clk_div_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
`ifdef CLKDIV_SYNC_EN
            .sync    (sync),
`endif
            .div_val (div_val[k*CW +: CW]),
            .clk_out (clk_out[k]),
            .tick    (tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (NCH=2, CW=8, DEF_DIV=2).
// Define CLKDIV_SYNC_EN to also exercise the sync phase-restart sequence.
module tb_clk_div_prog;

    localparam int NCH = 2;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [NCH*CW-1:0] div_val = '0;
`ifdef CLKDIV_SYNC_EN
    logic              sync = 1'b0;
`endif
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [NCH-1:0] o;
        logic [NCH-1:0] t;
        string          nm;
    } exp_t;
    exp_t sb[$];

    // Table rows: requested ratio per channel with the hand-derived period and high time.
    typedef struct {
        logic [7:0] d0;
        int         p0;
        int         h0;
        logic [7:0] d1;
        int         p1;
        int         h1;
    } vec_t;
    vec_t vt[6];

    clk_div_prog #(.NCH(NCH), .CW(CW), .DEF_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [NCH-1:0] eo, input logic [NCH-1:0] et);
        n_vec++;
        if (clk_out !== eo || tick !== et) begin
            n_err++;
            $display("FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b @%0t",
                     nm, clk_out, tick, eo, et, $time);
        end
    endtask

    // Push the expectation for the coming edge, then check it just after the edge.
    task automatic edge_chk(input logic [NCH-1:0] eo, input logic [NCH-1:0] et, input string nm);
        exp_t e;
        e.o  = eo;
        e.t  = et;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, expected one entry", nm);
        end else begin
            e = sb.pop_front();
            compare(e.nm, e.o, e.t);
        end
    endtask

    // Expected outputs for both channels at a given phase count since a common period start.
    task automatic phase_chk(input int k, input int p0, input int h0, input int p1, input int h1,
                             input string nm);
        logic [NCH-1:0] eo;
        logic [NCH-1:0] et;
        eo[0] = ((k % p0) < h0);
        et[0] = ((k % p0) == 0);
        eo[1] = ((k % p1) < h1);
        et[1] = ((k % p1) == 0);
        edge_chk(eo, et, nm);
    endtask

    // Reset, release with en=1; edge 1 finishes the DEF_DIV period, edge 2 starts the new ratio.
    task automatic start_run(input logic [7:0] d0, input logic [7:0] d1);
        rst     = 1'b1;
        en      = 1'b0;
        div_val = {d1, d0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        edge_chk(2'b00, 2'b00, "first_edge");
    endtask

    initial begin
        vt[0] = '{8'd2,   2,   1,   8'd4, 4, 2};
        vt[1] = '{8'd3,   3,   2,   8'd2, 2, 1};
        vt[2] = '{8'd0,   2,   1,   8'd1, 2, 1};
        vt[3] = '{8'd6,   6,   3,   8'd5, 5, 3};
        vt[4] = '{8'd255, 255, 128, 8'd7, 7, 4};
        vt[5] = '{8'd4,   4,   2,   8'd3, 3, 2};

        #2;
        compare("reset_state", 2'b00, 2'b00);

        for (int i = 0; i < 6; i++) begin
            int pm;
            start_run(vt[i].d0, vt[i].d1);
            pm = (vt[i].p0 > vt[i].p1) ? vt[i].p0 : vt[i].p1;
            for (int k = 0; k < 2 * pm + 2; k++)
                phase_chk(k, vt[i].p0, vt[i].h0, vt[i].p1, vt[i].h1, $sformatf("table_row%0d", i));
        end

        // Ratio 4 -> 6 on channel 0 requested at cnt=1; a transient write mid-period is ignored.
        start_run(8'd4, 8'd4);
        edge_chk(2'b11, 2'b11, "chg_start4");
        edge_chk(2'b11, 2'b00, "chg_cnt1");
        div_val[7:0] = 8'd6;
        edge_chk(2'b00, 2'b00, "chg_cnt2");
        edge_chk(2'b00, 2'b00, "chg_cnt3");
        edge_chk(2'b11, 2'b11, "chg_start6");
        for (int k = 1; k < 13; k++) begin
            if (k == 2) div_val[7:0] = 8'd3;
            if (k == 4) div_val[7:0] = 8'd6;
            phase_chk(k, 6, 3, 4, 2, "chg_run6");
        end

        // en low for 5 cycles right after a tick: level holds, tick clears, count resumes.
        start_run(8'd4, 8'd4);
        edge_chk(2'b11, 2'b11, "frz_tick");
        en = 1'b0;
        for (int k = 0; k < 5; k++) edge_chk(2'b11, 2'b00, "frz_hold");
        en = 1'b1;
        edge_chk(2'b11, 2'b00, "frz_resume1");
        edge_chk(2'b00, 2'b00, "frz_resume2");
        edge_chk(2'b00, 2'b00, "frz_resume3");
        edge_chk(2'b11, 2'b11, "frz_next");

        // Asynchronous reset while clk_out is high, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst", 2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        edge_chk(2'b00, 2'b00, "post_rst1");
        edge_chk(2'b11, 2'b11, "post_rst2");
        edge_chk(2'b11, 2'b00, "post_rst3");

`ifdef CLKDIV_SYNC_EN
        // Sync while en=0 realigns channels at ratios 3 and 5.
        start_run(8'd3, 8'd5);
        for (int k = 0; k < 4; k++) phase_chk(k, 3, 2, 5, 3, "pre_sync");
        en   = 1'b0;
        sync = 1'b1;
        edge_chk(2'b11, 2'b11, "sync_edge");
        sync = 1'b0;
        en   = 1'b1;
        for (int k = 1; k < 16; k++) phase_chk(k, 3, 2, 5, 3, "post_sync");
`endif

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
